// File: rtl/c499_key_loader.sv
// Serial key loader for a logic-locked c499: shifts in KEY_W key bits plus an
// odd-parity bit, verifies them and then holds the checked key on s.
module c499_key_loader #(
  parameter int KEY_W   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             key_clr,
  input  logic             key_sin,
  input  logic             key_sin_vld,
  output logic [KEY_W-1:0] s,
  output logic             key_rdy,
  output logic             key_err,
  output logic             busy
);

  localparam int CNT_W = $clog2(KEY_W + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SHIFT  = 3'd1;
  localparam logic [2:0] CHECK  = 3'd2;
  localparam logic [2:0] LOCKED = 3'd3;
  localparam logic [2:0] ERROR  = 3'd4;

  logic [2:0]       state;
  logic [KEY_W-1:0] shift_reg;
  logic             parity;
  logic [CNT_W-1:0] bit_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  // Key bits land in a private shift register; s is only written on entry to
  // LOCKED so the locked circuit never sees a partially loaded key.
  // NOTE: every register here is assigned with <= so all updates in the block
  // see the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      parity    <= 1'b0;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
      s         <= '0;
      key_rdy   <= 1'b0;
      key_err   <= 1'b0;
    end else if (key_clr) begin
      state     <= IDLE;
      shift_reg <= '0;
      parity    <= 1'b0;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
      s         <= '0;
      key_rdy   <= 1'b0;
      key_err   <= 1'b0;
    end else begin
      case (state)
        IDLE, ERROR: begin
          if (load_start) begin
            state     <= SHIFT;
            shift_reg <= '0;
            parity    <= 1'b0;
            bit_cnt   <= '0;
            tmo_cnt   <= '0;
            key_err   <= 1'b0;
          end
        end
        SHIFT: begin
          if (load_start) begin
            // Restart: the bit presented alongside load_start is dropped.
            shift_reg <= '0;
            parity    <= 1'b0;
            bit_cnt   <= '0;
            tmo_cnt   <= '0;
          end else if (key_sin_vld) begin
            tmo_cnt <= '0;
            if (bit_cnt == CNT_W'(KEY_W)) begin
              parity <= key_sin;
              state  <= CHECK;
            end else begin
              for (int i = 0; i < KEY_W; i++) begin
                if (bit_cnt == CNT_W'(i)) shift_reg[i] <= key_sin;
              end
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            state   <= ERROR;
            s       <= '0;
            key_rdy <= 1'b0;
            key_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        CHECK: begin
          if ((^shift_reg) ^ parity) begin
            state   <= LOCKED;
            s       <= shift_reg;
            key_rdy <= 1'b1;
          end else begin
            state   <= ERROR;
            s       <= '0;
            key_rdy <= 1'b0;
            key_err <= 1'b1;
          end
        end
        LOCKED: begin
          state <= LOCKED;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state == SHIFT) || (state == CHECK);

endmodule
